spi_mem_port: RTL and testbench

SPI memory port of the jrb8 computer: serves the CPU's byte-wide program-memory fetches (PC-addressed, ROM chip) and data-memory reads/writes (MAR-addressed, RAM chip) over one shared SPI bus using 23LC-style READ/WRITE commands. It sits directly upstream of the databus/CU. It presents a fetched byte plus a one-cycle `done` strobe, and holds `busy` high so the CPU clock divider stalls while a transfer is in flight.

---
 rtl/jrb8_spi_pkg.sv | 23 ++
 rtl/spi_shift_engine.sv | 77 +++++++
 rtl/spi_mem_port.sv | 114 +++++++++++
 tb/tb_spi_mem_port.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jrb8_spi_pkg.sv
// Shared constants and types for the jrb8 SPI memory port.
package jrb8_spi_pkg;

    localparam logic [7:0] SPI_OP_READ   = 8'h03;
    localparam logic [7:0] SPI_OP_WRITE  = 8'h02;
    localparam int         SPI_FRAME_LEN = 40;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } spi_state_e;

    // Frame layout sent MSB first: opcode, dummy byte, 16-bit address, data byte.
    function automatic logic [SPI_FRAME_LEN-1:0] spi_frame(
        input logic [7:0]  op,
        input logic [15:0] addr,
        input logic [7:0]  data
    );
        return {op, 8'h00, addr, data};
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: SCLK generation, 40-bit TX shift and 8-bit RX capture.
module spi_shift_engine
    import jrb8_spi_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [SPI_FRAME_LEN-1:0] frame_i,
    input  logic                     miso_i,
    output logic                     sclk_o,
    output logic                     mosi_o,
    output logic [7:0]               rx_o,
    output logic                     last_o
);

    localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'(SPI_FRAME_LEN - 1);

    logic                     active_q;
    logic                     sclk_q;
    logic                     mosi_q;
    logic [3:0]               div_q;
    logic [5:0]               bit_q;
    logic [SPI_FRAME_LEN-1:0] tx_q;
    logic [7:0]               rx_q;
    logic                     half_end;

    assign half_end = active_q && (div_q == DIV_MAX);
    assign last_o   = half_end && sclk_q && (bit_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else if (start_i) begin
            // Bit 39 goes out immediately; tx_q holds the remaining bits left-aligned.
            active_q <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= frame_i[SPI_FRAME_LEN-1];
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= {frame_i[SPI_FRAME_LEN-2:0], 1'b0};
        end else if (active_q) begin
            if (half_end) begin
                div_q <= '0;
                if (!sclk_q) begin
                    sclk_q <= 1'b1;
                    rx_q   <= {rx_q[6:0], miso_i};
                end else begin
                    sclk_q <= 1'b0;
                    if (bit_q == BIT_LAST) begin
                        active_q <= 1'b0;
                        mosi_q   <= 1'b0;
                    end else begin
                        bit_q  <= bit_q + 6'd1;
                        mosi_q <= tx_q[SPI_FRAME_LEN-1];
                        tx_q   <= {tx_q[SPI_FRAME_LEN-2:0], 1'b0};
                    end
                end
            end else begin
                div_q <= div_q + 4'd1;
            end
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign rx_o   = rx_q;

endmodule

// File: rtl/spi_mem_port.sv
// jrb8 SPI memory port: arbitrates ROM fetches and RAM reads/writes onto one SPI bus.
module spi_mem_port
    import jrb8_spi_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rom_rd_req,
    input  logic [15:0] rom_addr,
    input  logic        ram_rd_req,
    input  logic        ram_wr_req,
    input  logic [15:0] ram_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        done,
    output logic        busy,
    output logic        sclk,
    output logic        cs_rom_n,
    output logic        cs_ram_n,
    output logic        mosi,
    input  logic        miso
);

    spi_state_e               state_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     is_read_q;
    logic                     cs_rom_n_q;
    logic                     cs_ram_n_q;
    logic [7:0]               rd_data_q;

    logic                     req_any;
    logic                     sel_ram;
    logic                     start;
    logic [SPI_FRAME_LEN-1:0] frame_d;
    logic                     shift_last;
    logic [7:0]               rx_byte;

    // Fixed priority: RAM write, then RAM read, then ROM fetch.
    always_comb begin
        req_any = ram_wr_req | ram_rd_req | rom_rd_req;
        sel_ram = ram_wr_req | ram_rd_req;
        start   = (state_q == IDLE) && req_any;
        frame_d = spi_frame(ram_wr_req ? SPI_OP_WRITE : SPI_OP_READ,
                            sel_ram    ? ram_addr     : rom_addr,
                            ram_wr_req ? wr_data      : 8'h00);
    end

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .frame_i (frame_d),
        .miso_i  (miso),
        .sclk_o  (sclk),
        .mosi_o  (mosi),
        .rx_o    (rx_byte),
        .last_o  (shift_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            is_read_q  <= 1'b0;
            cs_rom_n_q <= 1'b1;
            cs_ram_n_q <= 1'b1;
            rd_data_q  <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        state_q    <= SHIFT;
                        busy_q     <= 1'b1;
                        is_read_q  <= !ram_wr_req;
                        cs_ram_n_q <= !sel_ram;
                        cs_rom_n_q <= sel_ram;
                    end
                end
                SHIFT: begin
                    // CS rises with the final SCLK fall so FINISH plus one IDLE cycle give the 2-cycle gap.
                    if (shift_last) begin
                        state_q    <= FINISH;
                        done_q     <= 1'b1;
                        cs_rom_n_q <= 1'b1;
                        cs_ram_n_q <= 1'b1;
                        if (is_read_q) begin
                            rd_data_q <= rx_byte;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign cs_rom_n = cs_rom_n_q;
    assign cs_ram_n = cs_ram_n_q;

endmodule

// File: tb/tb_spi_mem_port.sv
// Randomized bench for spi_mem_port with a behavioural 23LC-style ROM/RAM slave.
module tb_spi_mem_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_rd_req = 1'b0;
    logic        ram_rd_req = 1'b0;
    logic        ram_wr_req = 1'b0;
    logic [15:0] rom_addr = 16'h0000;
    logic [15:0] ram_addr = 16'h0000;
    logic [7:0]  wr_data = 8'h00;
    logic        miso = 1'b0;
    logic        sel3 = 1'b0;

    logic [7:0]  rd_data1, rd_data3;
    logic        done1, done3, busy1, busy3, sclk1, sclk3;
    logic        cs_rom_n1, cs_rom_n3, cs_ram_n1, cs_ram_n3, mosi1, mosi3;

    always #5 clk = ~clk;

    spi_mem_port #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rom_rd_req(rom_rd_req), .rom_addr(rom_addr),
        .ram_rd_req(ram_rd_req), .ram_wr_req(ram_wr_req), .ram_addr(ram_addr),
        .wr_data(wr_data), .rd_data(rd_data1), .done(done1), .busy(busy1),
        .sclk(sclk1), .cs_rom_n(cs_rom_n1), .cs_ram_n(cs_ram_n1), .mosi(mosi1), .miso(miso)
    );

    spi_mem_port #(.CLK_DIV(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rom_rd_req(rom_rd_req), .rom_addr(rom_addr),
        .ram_rd_req(ram_rd_req), .ram_wr_req(ram_wr_req), .ram_addr(ram_addr),
        .wr_data(wr_data), .rd_data(rd_data3), .done(done3), .busy(busy3),
        .sclk(sclk3), .cs_rom_n(cs_rom_n3), .cs_ram_n(cs_ram_n3), .mosi(mosi3), .miso(miso)
    );

    // The slave and the checks follow whichever DUT is selected.
    wire [7:0] s_rd_data  = sel3 ? rd_data3  : rd_data1;
    wire       s_done     = sel3 ? done3     : done1;
    wire       s_busy     = sel3 ? busy3     : busy1;
    wire       s_sclk     = sel3 ? sclk3     : sclk1;
    wire       s_cs_rom_n = sel3 ? cs_rom_n3 : cs_rom_n1;
    wire       s_cs_ram_n = sel3 ? cs_ram_n3 : cs_ram_n1;
    wire       s_mosi     = sel3 ? mosi3     : mosi1;
    wire       s_cs_idle  = s_cs_rom_n & s_cs_ram_n;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents: ROM is a fixed hash with a few pinned bytes, RAM starts at zero.
    logic [7:0] rom_over [logic [15:0]];
    logic [7:0] ram_mem  [logic [15:0]];
    logic [7:0] ref_ram  [logic [15:0]];

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        if (rom_over.exists(a)) return rom_over[a];
        return (a[7:0] * 8'd37) ^ a[15:8];
    endfunction

    function automatic logic [7:0] ram_val(input logic [15:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_val(input logic [15:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
    endfunction

    logic [39:0] sl_frame = '0;
    int          sl_bits = 0;
    logic        sl_rom = 1'b0;
    logic [7:0]  sl_byte = 8'h00;
    logic [39:0] last_frame = '0;
    int          last_bits = 0;
    int          both_low = 0;

    always @(negedge s_cs_idle) begin
        sl_bits  = 0;
        sl_frame = '0;
        sl_rom   = !s_cs_rom_n;
    end

    always @(posedge s_cs_idle) begin
        last_frame = sl_frame;
        last_bits  = sl_bits;
        if (sl_bits == 40 && !sl_rom && sl_frame[39:32] == 8'h02)
            ram_mem[sl_frame[23:8]] = sl_frame[7:0];
    end

    always @(posedge s_sclk) begin
        if (!s_cs_idle) begin
            sl_frame = {sl_frame[38:0], s_mosi};
            sl_bits++;
        end
    end

    // Mode 0: the slave changes MISO on the falling edge ahead of the next rising edge.
    always @(negedge s_sclk) begin
        if (!s_cs_idle) begin
            if (sl_bits == 32)
                sl_byte = sl_rom ? rom_val(sl_frame[15:0]) : ram_val(sl_frame[15:0]);
            if (sl_bits >= 32 && sl_bits < 40) miso = sl_byte[39 - sl_bits];
            else miso = 1'($urandom);
        end
    end

    always @(negedge clk) begin
        if (!s_cs_rom_n && !s_cs_ram_n) both_low <= both_low + 1;
    end

    // kind: 0 = ROM read, 1 = RAM read, 2 = RAM write.
    task automatic run_txn(input int kind, input logic [15:0] addr, input logic [7:0] wd);
        int          t0, hi, first_hi, d;
        logic [7:0]  op, rd_before, exp_rd;
        logic [39:0] exp_frame;
        d = sel3 ? 3 : 1;
        @(negedge clk);
        rd_before = s_rd_data;
        op        = (kind == 2) ? 8'h02 : 8'h03;
        exp_frame = {op, 8'h00, addr, (kind == 2) ? wd : 8'h00};
        exp_rd    = (kind == 0) ? rom_val(addr) : (kind == 1) ? ref_val(addr) : rd_before;
        if (kind == 2) ref_ram[addr] = wd;
        rom_addr   = (kind == 0) ? addr : 16'($urandom);
        ram_addr   = (kind != 0) ? addr : 16'($urandom);
        wr_data    = wd;
        rom_rd_req = (kind == 0);
        ram_rd_req = (kind == 1);
        ram_wr_req = (kind == 2);
        @(negedge clk);
        t0 = cyc;
        check("busy_at_accept", 64'(s_busy), 64'(1));
        check("cs_select", 64'({s_cs_rom_n, s_cs_ram_n}), (kind == 0) ? 64'(2'b01) : 64'(2'b10));
        rom_addr = 16'($urandom);
        ram_addr = 16'($urandom);
        wr_data  = 8'($urandom);
        hi = 0;
        first_hi = -1;
        for (int k = 0; k < 100 * d && s_done !== 1'b1; k++) begin
            if (s_sclk === 1'b1) begin
                hi++;
                if (first_hi < 0) first_hi = cyc - t0;
            end
            @(negedge clk);
        end
        check("done_latency", 64'(cyc - t0), 64'(80 * d));
        check("first_sclk_rise", 64'(first_hi), 64'(d));
        check("sclk_high_cycles", 64'(hi), 64'(40 * d));
        check("rd_data", 64'(s_rd_data), 64'(exp_rd));
        check("cs_released", 64'({s_cs_rom_n, s_cs_ram_n}), 64'(2'b11));
        rom_rd_req = 1'b0;
        ram_rd_req = 1'b0;
        ram_wr_req = 1'b0;
        check("frame", 64'(last_frame), 64'(exp_frame));
        check("frame_bits", 64'(last_bits), 64'(40));
        @(negedge clk);
        check("done_one_cycle", 64'(s_done), 64'(0));
        check("busy_idle", 64'(s_busy), 64'(0));
        check("rd_data_hold", 64'(s_rd_data), 64'(exp_rd));
    endtask

    initial begin
        int          k, nd, busy_low, t0, t_done_prev;
        int          t_d [3];
        logic [7:0]  exp_rom;
        logic [15:0] a;
        int          kind;

        rom_over[16'h1234] = 8'hA5;
        rom_over[16'h0001] = 8'h5C;
        rom_over[16'h0100] = 8'h7E;
        rom_over[16'h0200] = 8'hC3;
        rom_over[16'hFFFF] = 8'h81;

        repeat (3) @(negedge clk);
        check("rst_rd_data", 64'(s_rd_data), 64'(0));
        check("rst_done", 64'(s_done), 64'(0));
        check("rst_busy", 64'(s_busy), 64'(0));
        check("rst_sclk", 64'(s_sclk), 64'(0));
        check("rst_mosi", 64'(s_mosi), 64'(0));
        check("rst_cs", 64'({s_cs_rom_n, s_cs_ram_n}), 64'(2'b11));
        rst_n = 1'b1;

        run_txn(0, 16'h1234, 8'h00);
        run_txn(2, 16'h00FE, 8'h3C);
        run_txn(1, 16'h00FE, 8'h00);

        // All three requests at once: write, then RAM read, then ROM fetch.
        @(negedge clk);
        ram_addr = 16'h0040;
        wr_data  = 8'h5A;
        rom_addr = 16'h0100;
        ref_ram[16'h0040] = 8'h5A;
        exp_rom = rom_val(16'h0100);
        ram_wr_req = 1'b1;
        ram_rd_req = 1'b1;
        rom_rd_req = 1'b1;
        t_done_prev = 0;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (s_busy !== 1'b1 && k < 10) begin
                @(negedge clk);
                k++;
            end
            t0 = cyc;
            if (i > 0) check("cs_gap", 64'(t0 - t_done_prev), 64'(2));
            check("order_cs", 64'({s_cs_rom_n, s_cs_ram_n}), (i == 2) ? 64'(2'b01) : 64'(2'b10));
            k = 0;
            while (s_done !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
            t_done_prev = cyc;
            check("order_latency", 64'(t_done_prev - t0), 64'(80));
            check("order_op", 64'(last_frame[39:32]), (i == 0) ? 64'(8'h02) : 64'(8'h03));
            if (i == 1) check("order_ram_rd", 64'(s_rd_data), 64'(8'h5A));
            if (i == 2) check("order_rom_rd", 64'(s_rd_data), 64'(exp_rom));
            if (i == 0) ram_wr_req = 1'b0;
            if (i == 1) ram_rd_req = 1'b0;
            if (i == 2) rom_rd_req = 1'b0;
            @(negedge clk);
            check("done_single", 64'(s_done), 64'(0));
        end

        // ROM request held high across three transactions.
        rom_addr   = 16'h0200;
        rom_rd_req = 1'b1;
        nd = 0;
        busy_low = 0;
        t_d[0] = 0; t_d[1] = 0; t_d[2] = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (s_done === 1'b1) begin
                if (nd < 3) t_d[nd] = cyc;
                nd++;
                if (nd == 3) rom_rd_req = 1'b0;
            end
            if (nd >= 1 && nd < 3 && s_busy === 1'b0) busy_low++;
        end
        check("held_done_count", 64'(nd), 64'(3));
        check("held_spacing_1", 64'(t_d[1] - t_d[0]), 64'(82));
        check("held_spacing_2", 64'(t_d[2] - t_d[1]), 64'(82));
        check("held_busy_low", 64'(busy_low), 64'(2));
        check("held_rd_data", 64'(s_rd_data), 64'(8'hC3));

        for (int j = 0; j < 20; j++) begin
            kind = int'($urandom_range(0, 2));
            a = (kind == 0) ? 16'($urandom) : {12'h000, 4'($urandom)};
            run_txn(kind, a, 8'($urandom));
        end

        // Reset in the middle of a ROM fetch.
        @(negedge clk);
        rom_addr   = 16'h4321;
        rom_rd_req = 1'b1;
        @(negedge clk);
        rom_rd_req = 1'b0;
        k = 0;
        while (sl_bits < 20 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("mid_bit20", 64'(sl_bits), 64'(20));
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs", 64'({s_cs_rom_n, s_cs_ram_n}), 64'(2'b11));
        check("mid_rst_sclk", 64'(s_sclk), 64'(0));
        check("mid_rst_busy", 64'(s_busy), 64'(0));
        check("mid_rst_rd_data", 64'(s_rd_data), 64'(0));
        check("mid_rst_mosi", 64'(s_mosi), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, 16'h0001, 8'h00);

        // Switch to the CLK_DIV=3 instance from a clean reset.
        @(negedge clk);
        rst_n = 1'b0;
        rom_rd_req = 1'b0;
        ram_rd_req = 1'b0;
        ram_wr_req = 1'b0;
        repeat (2) @(negedge clk);
        sel3 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, 16'hFFFF, 8'h00);
        for (int j = 0; j < 4; j++) begin
            kind = int'($urandom_range(0, 2));
            a = (kind == 0) ? 16'($urandom) : {12'h000, 4'($urandom)};
            run_txn(kind, a, 8'($urandom));
        end

        check("cs_never_both_low", 64'(both_low), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
